// File: rtl/adder_pkg.sv
// Shared types and defaults for the chunk-serial adder (adder_seq / chunk_add).
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that indexes n items; never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit adder slice with carry in/out, used once per clock by adder_seq.
module chunk_add
  import adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    s     = total[CHUNK-1:0];
    cout  = total[CHUNK];
  end

endmodule

// File: rtl/adder_seq.sv
// Chunk-serial adder: adds CHUNK bits per clock, LSB first, with valid/ready on both sides.
// Optional subtract mode (a + ~b + 1) is enabled by defining ADDER_SEQ_SUB_EN.
module adder_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK     = WIDTH / CHUNK_SAFE;
  localparam int IDXW       = idx_bits(NCHUNK);
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  generate
    if (CHUNK < 1) begin : g_bad_chunk
      $error("adder_seq: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK_SAFE) != 0) begin : g_bad_width
      $error("adder_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;

  logic             accept;
  logic             last_chunk;
  logic             sub_sel;
  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
  logic             chunk_cout;

`ifdef ADDER_SEQ_SUB_EN
  assign sub_sel = op;
`else
  logic unused_op;
  assign unused_op = op;
  assign sub_sel   = 1'b0;
`endif

  assign accept     = in_valid && (state_q == IDLE);
  assign last_chunk = (idx_q == LAST);
  assign chunk_a    = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign chunk_b    = b_q[int'(idx_q)*CHUNK +: CHUNK];

  chunk_add #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_cout)
  );

  // State register plus datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (last_chunk) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // B is stored pre-inverted for subtract so the CALC path is a plain add.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    if (accept) begin
      a_d     = a;
      b_d     = sub_sel ? ~b : b;
      carry_d = sub_sel;
      idx_d   = '0;
    end else if (state_q == CALC) begin
      res_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_s;
      carry_d = chunk_cout;
      idx_d   = idx_q + 1'b1;
      if (last_chunk) begin
        sum_d = {chunk_cout, res_d};
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
  end

endmodule

// File: doc/adder_seq.md
ADDER_SEQ -- requirements
Module: adder_seq

Interface
- REQ-001: Parameter WIDTH SHALL exist: default 16, operand width in bits.
- REQ-002: Parameter CHUNK SHALL exist: default 4, bits added per clock cycle.
- REQ-003: Port clk SHALL exist: input, 1 bit, single clock, all state updates on its rising edge.
- REQ-004: Port rst SHALL exist: input, 1 bit, reset, synchronous and active-high.
- REQ-005: Port in_valid SHALL exist: input, 1 bit, operands a/b/op are valid.
- REQ-006: Port in_ready SHALL exist: output, 1 bit, block can accept operands.
- REQ-007: Port a SHALL exist: input, WIDTH bits, operand A, unsigned.
- REQ-008: Port b SHALL exist: input, WIDTH bits, operand B, unsigned.
- REQ-009: Port op SHALL exist: input, 1 bit, 0 = add, 1 = subtract; it only has effect under REQ-026.
- REQ-010: Port out_valid SHALL exist: output, 1 bit, sum is valid.
- REQ-011: Port out_ready SHALL exist: input, 1 bit, consumer accepts sum.
- REQ-012: Port sum SHALL exist: output, WIDTH+1 bits, {carry_out, result}.

Function
- REQ-013: NCHUNK = WIDTH/CHUNK; WIDTH not a multiple of CHUNK, or CHUNK < 1, SHALL raise an elaboration error.
- REQ-014: FSM states SHALL be IDLE, CALC, DONE.
- REQ-015: in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is DONE.
- REQ-016: An operand handshake SHALL occur on an edge with in_valid && in_ready. On that edge the block SHALL:
  - latch a, b and op;
  - set the chunk index to 0 and the carry to the initial carry (0 for add);
  - go to CALC.
- REQ-017: Each CALC edge SHALL add chunk[idx] of A and B plus the carry, write that chunk of the result, update the carry and increment idx, chunks processed LSB first.
- REQ-018: On the edge processing chunk NCHUNK-1, the state SHALL go to DONE, with sum = {final carry, result}.
- REQ-019: Latency: out_valid SHALL rise exactly NCHUNK edges after the accept edge.
- REQ-020: In DONE, sum and out_valid SHALL hold stable until out_valid && out_ready; on that edge the state SHALL go to IDLE.
- REQ-021: sum SHALL retain its last value in IDLE and CALC, and is meaningful only while out_valid = 1.
- REQ-022: Inputs a, b, op and in_valid SHALL be ignored outside IDLE; latched operands SHALL NOT change mid-operation.
- REQ-023: Back-to-back throughput with in_valid and out_ready held high SHALL be one operation per NCHUNK+2 cycles.
- REQ-024: In add mode, overflow SHALL be carried into sum[WIDTH]; no wrap-around or truncation.

Reset
- REQ-025: rst = 1 at a clock edge SHALL, taking priority over any handshake and in any state including mid-CALC, force:
  - state IDLE, in_ready 1, out_valid 0;
  - sum 0, carry 0, idx 0;
  - the in-flight operation discarded.

Configuration
- REQ-026: With macro ADDER_SEQ_SUB_EN defined:
  - op = 1 SHALL compute a + ~b + 1 (initial carry 1, B chunks inverted);
  - sum[WIDTH] = 1 means a >= b (no borrow);
  - sum[WIDTH-1:0] = (a - b) mod 2^WIDTH.
- REQ-027: Without ADDER_SEQ_SUB_EN, op SHALL be ignored and every operation SHALL be an add; port op SHALL still exist.

Structure
- REQ-028: Shared package adder_pkg SHALL hold the FSM state typedef (IDLE/CALC/DONE) and the default WIDTH/CHUNK constants.
- REQ-029: A combinational sub-module chunk_add (CHUNK-bit a, b, cin -> CHUNK-bit s, cout) SHALL perform the per-cycle addition; the FSM, registers and handshake live in adder_seq.

Verification
- REQ-030: Exhaustive check with WIDTH=4, CHUNK=1, all 256 (a,b) pairs, op=0: sum = a+b (e.g. 15+15 -> 5'h1E); out_valid exactly 4 edges after each accept.
- REQ-031: WIDTH=16, CHUNK=4, a=16'hFFFF, b=16'h0001 -> sum = 17'h10000; out_valid 4 edges after accept.
- REQ-032: Backpressure: after result 17'h10000, hold out_ready=0 for 10 cycles while driving in_valid=1 with new operands:
  - sum and out_valid stay stable;
  - in_ready stays 0;
  - no new operation is accepted;
  - release -> IDLE one edge later.
- REQ-033: Reset mid-CALC (rst pulse after 2 CALC edges):
  - next cycle: in_ready=1, out_valid=0, sum=0;
  - following op a=16'h1234, b=16'h4321 -> sum = 17'h05555.
- REQ-034: Back-to-back with in_valid and out_ready held high: accept edges spaced exactly 6 cycles (NCHUNK+2) apart, each result correct.
- REQ-035: With ADDER_SEQ_SUB_EN:
  - op=1, a=5, b=7 -> sum = 17'h0FFFE;
  - op=1, a=7, b=5 -> sum = 17'h10002;
  - without the macro, op=1, a=5, b=7 -> sum = 17'h0000C.
